// File: rtl/fifo_rr_scheduler.sv
// Purpose: round-robin drain of N_FIFO FIFOs into one registered stream, up to BURST words per grant.
// Latency: grant registers the edge after fifo_valid, fifo_re the cycle after, m_valid one cycle later; one bubble per grant.
// Backpressure: m_valid high with m_ready low holds m_data/m_sel/m_last and stops all FIFO reads.
// Build option: define FIFO_SCHED_BURST_EN for multi-word bursts; left undefined, every grant is exactly one word.
module fifo_rr_scheduler #(
  parameter int IN_WIDTH  = 16,
  parameter int N_FIFO    = 4,
  parameter int SEL_WIDTH = 2,
  parameter int BURST     = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_FIFO-1:0]          fifo_valid,
  input  logic [N_FIFO-1:0]          fifo_almost_empty,
  input  logic [N_FIFO*IN_WIDTH-1:0] fifo_dout,
  output logic [N_FIFO-1:0]          fifo_re,
  output logic [IN_WIDTH-1:0]        m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [SEL_WIDTH-1:0]       m_sel,
  output logic                       m_last
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N_FIFO - 1);

  logic [0:0]           state;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] next_ptr;
  logic [SEL_WIDTH-1:0] arb_idx;
  logic [SEL_WIDTH-1:0] cand_idx;
  logic                 arb_found;
  logic                 pop;
  logic                 grant_dry;
  logic                 last_word;
  logic [IN_WIDTH-1:0]  dout_arr [N_FIFO];
  logic [IN_WIDTH-1:0]  head_word;

  // Split the flat head-word bus into one entry per FIFO.
  always_comb begin
    for (int i = 0; i < N_FIFO; i++) begin
      dout_arr[i] = fifo_dout[i*IN_WIDTH +: IN_WIDTH];
    end
  end

  assign head_word = dout_arr[grant];

  // Round-robin search: first valid index at or above rr_ptr, wrapping past N_FIFO-1 to 0.
  always_comb begin
    int cand;
    cand      = 0;
    cand_idx  = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < N_FIFO; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_FIFO) begin
        cand = cand - N_FIFO;
      end
      cand_idx = cand[SEL_WIDTH-1:0];
      if (!arb_found && fifo_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // A pop needs the granted FIFO non-empty and the output register free or draining this cycle.
  assign pop = (state == SERVE) && fifo_valid[grant] && (!m_valid || m_ready);

  // The granted FIFO ran dry without flagging its final word; release the grant rather than stall forever.
  assign grant_dry = (state == SERVE) && !fifo_valid[grant];

  assign next_ptr = (grant == LAST_IDX) ? '0 : grant + 1'b1;

  // Read enable: only the granted FIFO, only on a pop.
  always_comb begin
    fifo_re = '0;
    if (pop) begin
      fifo_re[grant] = 1'b1;
    end
  end

`ifdef FIFO_SCHED_BURST_EN
  localparam int CNT_W = $clog2(BURST) + 1;

  logic [CNT_W-1:0] cnt;

  // The grant ends on the BURST-th word or on the FIFO's last word; a late write to that FIFO does not extend it.
  assign last_word = (cnt == CNT_W'(BURST - 1)) || fifo_almost_empty[grant];

  // Words popped so far in the current grant; cleared whenever the grant ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= last_word ? '0 : cnt + 1'b1;
    end else if (grant_dry) begin
      cnt <= '0;
    end
  end
`else
  logic unused_cfg;

  // Single-word grants: every pop closes its grant, so the fill flag and burst length play no part.
  assign last_word  = 1'b1;
  assign unused_cfg = ^{fifo_almost_empty, (BURST > 0)};
`endif

  // Grant FSM: IDLE picks the next FIFO, SERVE drains it until its last word pops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_idx;
            state <= SERVE;
          end
        end
        SERVE: begin
          if ((pop && last_word) || grant_dry) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load on a pop, hold under backpressure, drop valid once the word is taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= '0;
      m_last  <= 1'b0;
    end else if (pop) begin
      m_valid <= 1'b1;
      m_data  <= head_word;
      m_sel   <= grant;
      m_last  <= last_word;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 Parameter IN_WIDTH, default 16, word width of every FIFO and of the output.
REQ-002 Parameter N_FIFO, default 4, number of FIFOs drained.
REQ-003 Parameter SEL_WIDTH, default 2, width of the grant index; equals $clog2(N_FIFO).
REQ-004 Parameter BURST, default 4, maximum words popped per grant.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rstn, input, 1, asynchronous active-low reset.
REQ-007 Port fifo_valid, input, N_FIFO, per-FIFO not-empty flag (r_valid).
REQ-008 Port fifo_almost_empty, input, N_FIFO, per-FIFO exactly-one-word flag.
REQ-009 Port fifo_dout, input, N_FIFO*IN_WIDTH, FIFO i head word at bits [i*IN_WIDTH +: IN_WIDTH].
REQ-010 Port fifo_re, output, N_FIFO, per-FIFO read enable; at most one bit high.
REQ-011 Port m_data, output, IN_WIDTH, registered output word.
REQ-012 Port m_valid, output, 1, m_data holds a word.
REQ-013 Port m_ready, input, 1, downstream accepts m_data when m_valid and m_ready are both high.
REQ-014 Port m_sel, output, SEL_WIDTH, index of the FIFO that sourced m_data.
REQ-015 Port m_last, output, 1, m_data is the final word of its grant.

Function
REQ-016 The block SHALL run a two-state FSM, IDLE and SERVE.
REQ-017 In IDLE with any fifo_valid bit high, the block SHALL register grant = first valid index searched upward from rr_ptr, with wrap-around modulo N_FIFO, and enter SERVE on the next edge.
REQ-018 In IDLE with all fifo_valid bits low, the block SHALL remain in IDLE with fifo_re = 0.
REQ-019 In SERVE, fifo_re[grant] SHALL equal fifo_valid[grant] & (!m_valid | m_ready); all other fifo_re bits SHALL be 0.
REQ-020 On a pop, the block SHALL register m_data <= fifo_dout[grant], m_sel <= grant, m_valid <= 1 and cnt <= cnt + 1.
REQ-021 On a pop, m_last SHALL register 1 when cnt == BURST-1 or fifo_almost_empty[grant] is high, and 0 otherwise.
REQ-022 A pop that sets m_last SHALL return the FSM to IDLE, clear cnt, and set rr_ptr <= grant + 1, wrapping from N_FIFO-1 to 0.
REQ-023 With m_valid high and m_ready low, m_data, m_sel and m_last SHALL hold unchanged and no pop SHALL occur.
REQ-024 When m_ready is high and no pop occurs in the same cycle, m_valid SHALL clear.
REQ-025 Latency: with fifo_valid rising in cycle 0 in IDLE, SERVE is entered in cycle 1, the first fifo_re is high in cycle 1, and m_valid is high in cycle 2.
REQ-026 At full throughput (m_ready held high), the block SHALL pop one word per cycle in SERVE.
REQ-027 The return to IDLE costs one bubble cycle per grant.
REQ-028 A write into the granted FIFO while fifo_almost_empty is high SHALL NOT extend the grant; the burst ends as stated in REQ-021.
REQ-029 cnt SHALL be $clog2(BURST)+1 bits wide and SHALL never exceed BURST-1.

Reset
REQ-030 While rstn is low, state = IDLE, rr_ptr = 0, grant = 0, cnt = 0, fifo_re = 0, m_valid = 0, m_data = 0, m_sel = 0 and m_last = 0, regardless of clk.
REQ-031 A reset asserted mid-burst SHALL drop the in-flight output word; after release, arbitration restarts from index 0.

Configuration
REQ-032 Macro FIFO_SCHED_BURST_EN, when defined, SHALL enable burst grants of up to BURST words as specified above.
REQ-033 When FIFO_SCHED_BURST_EN is undefined, every grant SHALL be exactly one word: m_last = 1 on every pop, the BURST parameter is ignored, and cnt logic is not built.

Verification
REQ-034 FIFO 2 holds 6 words, the others are empty, m_ready = 1 (BURST_EN defined): m_sel = 2 for a run of 4 words with m_last on word 4, one bubble, then 2 words with m_last on word 2.
REQ-035 All 4 FIFOs hold 1 word each (values 0xA0..0xA3), m_ready = 1: output order 0xA0, 0xA1, 0xA2, 0xA3, with m_last = 1 on every word.
REQ-036 FIFO 3 is served and then FIFO 0 is refilled while FIFO 3 still holds data: the next grant goes to FIFO 0 (wrap from rr_ptr = 0), not to FIFO 3.
REQ-037 m_ready is held low for 5 cycles mid-burst: m_data, m_sel and m_last stay constant, fifo_re stays 0, and the sequence resumes with no loss or duplication.
REQ-038 rstn is pulsed low mid-burst, asynchronously to clk: all outputs go to 0 immediately; after release the first grant goes to the lowest-index valid FIFO.
REQ-039 With BURST_EN undefined, FIFO 1 holds 3 words and FIFO 2 holds 3 words: the output m_sel sequence is 1, 2, 1, 2, 1, 2.
